// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and constants for the multi-bus packet arbiter.
// Lane states, destination ID width and arbitration mode selectors.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } lane_state_t;

  localparam int ID_W       = 8;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/bus_arbiter_rr_lane.sv
// One bus lane: arbitrates between device FIFOs, pops the winner's head packet,
// then pushes it to the decoded destination(s) or counts it as dropped.
module bus_arb_lane
  import bus_arb_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF,
  parameter int              MODE      = MODE_RR
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [drvrs-1:0]                 pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]    D_pop,
  output logic [drvrs-1:0]                 pop,
  output logic [drvrs-1:0]                 push,
  output logic [drvrs-1:0][pckg_sz-1:0]    D_push,
  output logic [ID_W-1:0]                  drop_cnt
);

  localparam int              SRC_W = $clog2(drvrs);
  localparam logic [SRC_W-1:0] LAST = SRC_W'(drvrs - 1);

  lane_state_t                   state_q, state_d;
  logic [SRC_W-1:0]              src_q, src_d;
  logic [SRC_W-1:0]              ptr_q, ptr_d;
  logic [pckg_sz-1:0]            pkt_q, pkt_d;
  logic [drvrs-1:0]              pop_q, pop_d;
  logic [drvrs-1:0]              push_q, push_d;
  logic [drvrs-1:0][pckg_sz-1:0] d_push_q, d_push_d;
  logic [ID_W-1:0]               drop_q, drop_d;

  logic [SRC_W-1:0]              base_s;
  logic [SRC_W-1:0]              grant_s;
  logic                          found_s;
  logic [ID_W-1:0]               dest_s;

  // Arbiter: first pending device at or after base, wrapping to the lowest index.
  always_comb begin
    base_s  = (MODE == MODE_RR) ? ptr_q : {SRC_W{1'b0}};
    grant_s = {SRC_W{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < drvrs; i++) begin
      if (!found_s && pndng[i] && (i >= int'(base_s))) begin
        grant_s = SRC_W'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < drvrs; i++) begin
      if (!found_s && pndng[i]) begin
        grant_s = SRC_W'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Lane FSM: next state, pointer, packet capture, strobes and drop counting.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    pkt_d    = pkt_q;
    pop_d    = {drvrs{1'b0}};
    push_d   = {drvrs{1'b0}};
    d_push_d = d_push_q;
    drop_d   = drop_q;
    dest_s   = pkt_q[pckg_sz-1 -: ID_W];
    case (state_q)
      IDLE: begin
        if (|pndng) begin
          state_d = POP;
          src_d   = grant_s;
          for (int d = 0; d < drvrs; d++) begin
            pop_d[d] = (SRC_W'(d) == grant_s);
          end
          if (MODE == MODE_RR) begin
            ptr_d = (grant_s == LAST) ? {SRC_W{1'b0}} : grant_s + 1'b1;
          end else begin
            ptr_d = ptr_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      POP: begin
        // The pushed data comes from the same value being latched this edge.
        state_d = PUSH;
        pkt_d   = D_pop[src_q];
        dest_s  = pkt_d[pckg_sz-1 -: ID_W];
        if (int'(dest_s) < drvrs) begin
          for (int d = 0; d < drvrs; d++) begin
            push_d[d]   = (d == int'(dest_s));
            d_push_d[d] = push_d[d] ? pkt_d : d_push_q[d];
          end
        end else if (dest_s == broadcast) begin
          for (int d = 0; d < drvrs; d++) begin
            push_d[d]   = (SRC_W'(d) != src_q);
            d_push_d[d] = push_d[d] ? pkt_d : d_push_q[d];
          end
        end else begin
          drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end
      end
      PUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      src_q    <= {SRC_W{1'b0}};
      ptr_q    <= {SRC_W{1'b0}};
      pkt_q    <= {pckg_sz{1'b0}};
      pop_q    <= {drvrs{1'b0}};
      push_q   <= {drvrs{1'b0}};
      d_push_q <= {(drvrs*pckg_sz){1'b0}};
      drop_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      ptr_q    <= ptr_d;
      pkt_q    <= pkt_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
      d_push_q <= d_push_d;
      drop_q   <= drop_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = d_push_q;
  assign drop_cnt = drop_q;

endmodule

// File: rtl/bus_arbiter_rr.sv
// Multi-bus packet arbiter top: one independent lane per bus, wiring only.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF,
  parameter int              MODE      = MODE_RR
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [bits-1:0][drvrs-1:0]                pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [bits-1:0][drvrs-1:0]                pop,
  output logic [bits-1:0][drvrs-1:0]                push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push,
  output logic [bits-1:0][ID_W-1:0]                 drop_cnt
);

  for (genvar b = 0; b < bits; b++) begin : g_lane
    bus_arb_lane #(
      .drvrs    (drvrs),
      .pckg_sz  (pckg_sz),
      .broadcast(broadcast),
      .MODE     (MODE)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .pndng   (pndng[b]),
      .D_pop   (D_pop[b]),
      .pop     (pop[b]),
      .push    (push[b]),
      .D_push  (D_push[b]),
      .drop_cnt(drop_cnt[b])
    );
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a round-robin instance and a fixed-priority
// instance, both with two buses of four devices and 16-bit packets.
module tb_bus_arbiter_rr;

  logic                         clk;
  logic                         reset;
  logic [1:0][3:0]              pndng, pndng_fp;
  logic [1:0][3:0][15:0]        d_pop, d_pop_fp;
  logic [1:0][3:0]              pop, push, pop_fp, push_fp;
  logic [1:0][3:0][15:0]        d_push, d_push_fp;
  logic [1:0][7:0]              drop_cnt, drop_cnt_fp;

  int compared   = 0;
  int mismatched = 0;
  int rr_ord [5] = '{0, 1, 2, 3, 0};

  bus_arbiter_rr #(.bits(2), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .MODE(1)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
    .pop(pop), .push(push), .D_push(d_push), .drop_cnt(drop_cnt)
  );

  bus_arbiter_rr #(.bits(2), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .pndng(pndng_fp), .D_pop(d_pop_fp),
    .pop(pop_fp), .push(push_fp), .D_push(d_push_fp), .drop_cnt(drop_cnt_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    pndng    = '0;
    pndng_fp = '0;
    d_pop    = '0;
    d_pop_fp = '0;
    #1;
    chk("rst_pop", 32'(pop), 32'h0);
    chk("rst_push", 32'(push), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_dpush", 32'(d_push[0][2]), 32'h0);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;

    // Unicast 1 -> 2
    pndng[0][1] = 1'b1;
    d_pop[0][1] = 16'h02A5;
    tick();
    chk("uni_pop", 32'(pop[0]), 32'b0010);
    chk("uni_push_low", 32'(push[0]), 32'b0000);
    pndng[0][1] = 1'b0;
    tick();
    chk("uni_push", 32'(push[0]), 32'b0100);
    chk("uni_data", 32'(d_push[0][2]), 32'h02A5);
    chk("uni_pop_low", 32'(pop[0]), 32'b0000);
    chk("uni_bus1", 32'(push[1]), 32'b0000);
    tick();
    chk("uni_done", 32'(push[0]), 32'b0000);

    // Broadcast from 0
    pndng[0][0] = 1'b1;
    d_pop[0][0] = 16'hFF11;
    tick();
    chk("bc_pop", 32'(pop[0]), 32'b0001);
    pndng[0][0] = 1'b0;
    tick();
    chk("bc_push", 32'(push[0]), 32'b1110);
    chk("bc_data1", 32'(d_push[0][1]), 32'hFF11);
    chk("bc_data3", 32'(d_push[0][3]), 32'hFF11);
    tick();

    // Invalid destination from 3
    pndng[0][3] = 1'b1;
    d_pop[0][3] = 16'h07C3;
    tick();
    chk("inv_pop", 32'(pop[0]), 32'b1000);
    pndng[0][3] = 1'b0;
    tick();
    chk("inv_nopush", 32'(push[0]), 32'b0000);
    chk("inv_drop", 32'(drop_cnt[0]), 32'd1);
    tick();

    // Round-robin vs fixed priority, all four pending
    for (int i = 0; i < 4; i++) begin
      d_pop[0][i]    = 16'h0010 + 16'(i);
      d_pop_fp[0][i] = 16'h0010 + 16'(i);
    end
    pndng[0]    = 4'b1111;
    pndng_fp[0] = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) repeat (3) tick();
      chk("rr_order", 32'(pop[0]), 32'(1) << rr_ord[k]);
      chk("fp_order", 32'(pop_fp[0]), 32'b0001);
    end
    pndng[0]    = 4'b0000;
    pndng_fp[0] = 4'b0000;
    repeat (2) tick();

    // Drop counter saturation
    d_pop[0][3] = 16'h07C3;
    pndng[0][3] = 1'b1;
    repeat (900) tick();
    pndng[0][3] = 1'b0;
    chk("sat_drop", 32'(drop_cnt[0]), 32'd255);
    chk("sat_bus1", 32'(drop_cnt[1]), 32'd0);

    // Bus independence
    pndng[0][2] = 1'b1;
    d_pop[0][2] = 16'h01BB;
    pndng[1][2] = 1'b1;
    d_pop[1][2] = 16'h01CC;
    tick();
    chk("ind_pop0", 32'(pop[0]), 32'b0100);
    chk("ind_pop1", 32'(pop[1]), 32'b0100);
    pndng[0][2] = 1'b0;
    pndng[1][2] = 1'b0;
    tick();
    chk("ind_push0", 32'(push[0]), 32'b0010);
    chk("ind_push1", 32'(push[1]), 32'b0010);
    chk("ind_data0", 32'(d_push[0][1]), 32'h01BB);
    chk("ind_data1", 32'(d_push[1][1]), 32'h01CC);
    tick();
    pndng[1][0] = 1'b1;
    d_pop[1][0] = 16'h55AA;
    tick();
    chk("ind_pop1_wrap", 32'(pop[1]), 32'b0001);
    chk("ind_pop0_idle", 32'(pop[0]), 32'b0000);
    pndng[1][0] = 1'b0;
    repeat (2) tick();
    chk("ind_drop1", 32'(drop_cnt[1]), 32'd1);
    chk("ind_drop0", 32'(drop_cnt[0]), 32'd255);
    pndng[0] = 4'b1111;
    tick();
    chk("ind_ptr0", 32'(pop[0]), 32'b1000);
    pndng[0] = 4'b0000;
    repeat (2) tick();

    // Reset mid-PUSH
    pndng[0][2] = 1'b1;
    d_pop[0][2] = 16'h03DD;
    tick();
    chk("rst6_pop", 32'(pop[0]), 32'b0100);
    pndng[0][2] = 1'b0;
    tick();
    chk("rst6_push", 32'(push[0]), 32'b1000);
    chk("rst6_data", 32'(d_push[0][3]), 32'h03DD);
    #2;
    reset = 1'b0;
    #1;
    chk("rst6_push_low", 32'(push), 32'h0);
    chk("rst6_pop_low", 32'(pop), 32'h0);
    chk("rst6_dpush", 32'(d_push[0][3]), 32'h0);
    chk("rst6_drop", 32'(drop_cnt), 32'h0);
    pndng[0][2] = 1'b1;
    pndng[0][3] = 1'b1;
    d_pop[0][3] = 16'h0033;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rst6_regrant", 32'(pop[0]), 32'b0100);
    pndng[0] = 4'b0000;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
